spi_slave_word: RTL and testbench

- Parametrised SPI slave, successor to the fixed 8-bit board SPI receiver.
- Word width is configurable. All four CPOL/CPHA modes are supported.
- Has valid/ready handshakes on both the RX and TX sides, back-to-back words within one SSEL frame, and sticky overrun/underrun flags.
- Sits between the external SPI master pins and fabric logic (seven-segment mux, LED/DIP registers).

---
 rtl/spi_slave_word_if.sv | 30 +++
 rtl/spi_slave_word.sv | 149 ++++++++++++++
 tb/tb_spi_slave_word.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_word_if.sv
// SPI pin and fabric handshake bundle for spi_slave_word.
// The slave modport is the SPI slave's view; master is the pins/fabric side.
interface spi_slave_word_if #(
  parameter int WIDTH = 8
);
  logic             SPI_SCK;
  logic             SPI_SI;
  logic             SPI_SSEL;
  logic             SPI_SO;
  logic [WIDTH-1:0] TX_DATA;
  logic             TX_VALID;
  logic             TX_READY;
  logic [WIDTH-1:0] RX_DATA;
  logic             RX_VALID;
  logic             RX_READY;
  logic             OVERRUN;
  logic             UNDERRUN;
  logic             FLAG_CLR;
  logic             FRAME_ACTIVE;

  modport slave (
    input  SPI_SCK, SPI_SI, SPI_SSEL, TX_DATA, TX_VALID, RX_READY, FLAG_CLR,
    output SPI_SO, TX_READY, RX_DATA, RX_VALID, OVERRUN, UNDERRUN, FRAME_ACTIVE
  );

  modport master (
    output SPI_SCK, SPI_SI, SPI_SSEL, TX_DATA, TX_VALID, RX_READY, FLAG_CLR,
    input  SPI_SO, TX_READY, RX_DATA, RX_VALID, OVERRUN, UNDERRUN, FRAME_ACTIVE
  );
endinterface

// File: rtl/spi_slave_word.sv
// Word-wide SPI slave, any CPOL/CPHA, with RX/TX handshakes and sticky flags.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float SPI_SO outside of a frame.
module spi_slave_word #(
  parameter int WIDTH = 8,
  parameter int CPOL  = 0,
  parameter int CPHA  = 0
) (
  input logic             CLKIN,
  input logic             RST,
  spi_slave_word_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
      $error("spi_slave_word: WIDTH must be in 2..32");
    end
  endgenerate

  logic [2:0]       sck_sync;
  logic [2:0]       ssel_sync;
  logic [1:0]       si_sync;
  logic             sck_rise;
  logic             sck_fall;
  logic             lead_edge;
  logic             trail_edge;
  logic             sample_edge;
  logic             drive_edge;
  logic             ssel_fall;
  logic             ssel_rise;
  logic             frame_active;
  logic             load_event;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] rx_data;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_hold;
  logic             rx_done;
  logic             rx_valid;
  logic             tx_full;
  logic             overrun;
  logic             underrun;
  logic             overrun_set;
  logic             underrun_set;

  // SSEL resets to the deasserted level so reset never looks like a frame start.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      sck_sync  <= (CPOL != 0) ? 3'b111 : 3'b000;
      ssel_sync <= 3'b111;
      si_sync   <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], bus.SPI_SCK};
      ssel_sync <= {ssel_sync[1:0], bus.SPI_SSEL};
      si_sync   <= {si_sync[0], bus.SPI_SI};
    end
  end

  assign sck_rise     = (sck_sync[2:1] == 2'b01);
  assign sck_fall     = (sck_sync[2:1] == 2'b10);
  assign ssel_fall    = (ssel_sync[2:1] == 2'b10);
  assign ssel_rise    = (ssel_sync[2:1] == 2'b01);
  assign frame_active = ~ssel_sync[1];
  assign lead_edge    = (CPOL == 0) ? sck_rise : sck_fall;
  assign trail_edge   = (CPOL == 0) ? sck_fall : sck_rise;
  assign sample_edge  = frame_active && ((CPHA == 0) ? lead_edge : trail_edge);
  assign drive_edge   = frame_active && ((CPHA == 0) ? trail_edge : lead_edge);
  assign load_event   = (drive_edge && (bit_cnt == '0)) || ((CPHA == 0) && ssel_fall);
  assign overrun_set  = rx_done && rx_valid && !bus.RX_READY;
  assign underrun_set = load_event && !tx_full;

  // A completed word is committed one cycle after its last sample edge.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_done  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (ssel_rise) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        rx_shift <= {rx_shift[WIDTH-2:0], si_sync[1]};
        if (bit_cnt == CW'(WIDTH - 1)) begin
          bit_cnt <= '0;
          rx_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
      if (rx_done && (!rx_valid || bus.RX_READY)) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && bus.RX_READY) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Load and accept never collide: a load only empties a full register, accept only fills an empty one.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      tx_shift <= '0;
      tx_hold  <= '0;
      tx_full  <= 1'b0;
    end else begin
      if (load_event) begin
        if (tx_full) begin
          tx_shift <= tx_hold;
          tx_full  <= 1'b0;
        end else begin
          tx_shift <= '1;
        end
      end else if (drive_edge) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end
      if (bus.TX_VALID && !tx_full) begin
        tx_hold <= bus.TX_DATA;
        tx_full <= 1'b1;
      end
    end
  end

  // A flag being set outranks a clear arriving in the same cycle.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= overrun_set  ? 1'b1 : (bus.FLAG_CLR ? 1'b0 : overrun);
      underrun <= underrun_set ? 1'b1 : (bus.FLAG_CLR ? 1'b0 : underrun);
    end
  end

  assign bus.RX_DATA      = rx_data;
  assign bus.RX_VALID     = rx_valid;
  assign bus.TX_READY     = ~tx_full;
  assign bus.OVERRUN      = overrun;
  assign bus.UNDERRUN     = underrun;
  assign bus.FRAME_ACTIVE = frame_active;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign bus.SPI_SO = frame_active ? tx_shift[WIDTH-1] : 1'bz;
`else
  assign bus.SPI_SO = tx_shift[WIDTH-1];
`endif
endmodule

// File: tb/tb_spi_slave_word.sv
// Directed bench for spi_slave_word: a bit-banged SPI master drives three
// instances (mode 0 / 8 bit, mode 3 / 16 bit, mode 1 / 8 bit).
module tb_spi_slave_word;
  localparam int HALF = 80;

  logic        clkin;
  logic        rst;
  logic        sck_raw;
  logic        mosi;
  logic        ssel;
  logic        miso;
  int          sel;
  int          vectors;
  int          miscompares;
  logic [31:0] rx;
  logic [31:0] r0;
  logic [31:0] r1;
  logic [31:0] r2;
  logic [15:0] rxq3[$];
  logic [15:0] exp_rx3[3];

  spi_slave_word_if #(.WIDTH(8))  b0 ();
  spi_slave_word_if #(.WIDTH(16)) b3 ();
  spi_slave_word_if #(.WIDTH(8))  b1 ();

  spi_slave_word #(.WIDTH(8),  .CPOL(0), .CPHA(0)) dut0 (.CLKIN(clkin), .RST(rst), .bus(b0));
  spi_slave_word #(.WIDTH(16), .CPOL(1), .CPHA(1)) dut3 (.CLKIN(clkin), .RST(rst), .bus(b3));
  spi_slave_word #(.WIDTH(8),  .CPOL(0), .CPHA(1)) dut1 (.CLKIN(clkin), .RST(rst), .bus(b1));

  // sck_raw is CPOL-normalised: its rising edge is always the leading edge.
  assign b0.SPI_SCK  = (sel == 0) && sck_raw;
  assign b1.SPI_SCK  = (sel == 1) && sck_raw;
  assign b3.SPI_SCK  = !((sel == 3) && sck_raw);
  assign b0.SPI_SSEL = (sel == 0) ? ssel : 1'b1;
  assign b1.SPI_SSEL = (sel == 1) ? ssel : 1'b1;
  assign b3.SPI_SSEL = (sel == 3) ? ssel : 1'b1;
  assign b0.SPI_SI   = mosi;
  assign b1.SPI_SI   = mosi;
  assign b3.SPI_SI   = mosi;

  always_comb begin
    miso = 1'b0;
    case (sel)
      0:       miso = b0.SPI_SO;
      1:       miso = b1.SPI_SO;
      default: miso = b3.SPI_SO;
    endcase
  end

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  always @(negedge clkin) begin
    if (b3.RX_VALID && b3.RX_READY) rxq3.push_back(b3.RX_DATA);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_ready_of(input int which);
    case (which)
      0:       return b0.TX_READY;
      1:       return b1.TX_READY;
      default: return b3.TX_READY;
    endcase
  endfunction

  task automatic set_tx(input int which, input logic valid, input logic [31:0] word);
    case (which)
      0:       begin b0.TX_VALID = valid; b0.TX_DATA = word[7:0];  end
      1:       begin b1.TX_VALID = valid; b1.TX_DATA = word[7:0];  end
      default: begin b3.TX_VALID = valid; b3.TX_DATA = word[15:0]; end
    endcase
  endtask

  task automatic push_tx(input int which, input logic [31:0] word);
    int   waited;
    logic rdy;
    waited = 0;
    rdy    = 1'b0;
    while (!rdy && waited < 2000) begin
      @(negedge clkin);
      rdy = tx_ready_of(which);
      waited++;
    end
    checkOutput("tx_ready_wait", {31'd0, rdy}, 32'd1);
    if (rdy) begin
      @(posedge clkin); #2;
      set_tx(which, 1'b1, word);
      @(posedge clkin); #2;
      set_tx(which, 1'b0, word);
    end
  endtask

  task automatic pulse_rx_ready0();
    @(posedge clkin); #2;
    b0.RX_READY = 1'b1;
    @(posedge clkin); #2;
    b0.RX_READY = 1'b0;
    @(negedge clkin);
  endtask

  task automatic pulse_flag_clr0();
    @(posedge clkin); #2;
    b0.FLAG_CLR = 1'b1;
    @(posedge clkin); #2;
    b0.FLAG_CLR = 1'b0;
    @(negedge clkin);
  endtask

  task automatic frame_start(input int which);
    sel  = which;
    ssel = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF;
    ssel = 1'b1;
    #(4 * HALF);
  endtask

  task automatic shift_word(input bit cpha, input int width, input int nbits,
                            input logic [31:0] tx, output logic [31:0] rxw);
    rxw = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[width-1-i];
        #HALF;
        sck_raw = 1'b1;
        rxw = {rxw[30:0], miso};
        #HALF;
        sck_raw = 1'b0;
      end else begin
        sck_raw = 1'b1;
        mosi = tx[width-1-i];
        #HALF;
        sck_raw = 1'b0;
        rxw = {rxw[30:0], miso};
        #HALF;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sel = 0; ssel = 1'b1; sck_raw = 1'b0; mosi = 1'b0;
    exp_rx3 = '{16'h1234, 16'hBEEF, 16'h0F0F};
    b0.TX_DATA = '0; b0.TX_VALID = 1'b0; b0.RX_READY = 1'b0; b0.FLAG_CLR = 1'b0;
    b1.TX_DATA = '0; b1.TX_VALID = 1'b0; b1.RX_READY = 1'b0; b1.FLAG_CLR = 1'b0;
    b3.TX_DATA = '0; b3.TX_VALID = 1'b0; b3.RX_READY = 1'b1; b3.FLAG_CLR = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clkin);
    #2 rst = 1'b0;
    @(negedge clkin);

    checkOutput("rst_rx_data",  b0.RX_DATA,      32'h0);
    checkOutput("rst_rx_valid", b0.RX_VALID,     32'h0);
    checkOutput("rst_overrun",  b0.OVERRUN,      32'h0);
    checkOutput("rst_underrun", b0.UNDERRUN,     32'h0);
    checkOutput("rst_frame",    b0.FRAME_ACTIVE, 32'h0);
    checkOutput("rst_tx_ready", b0.TX_READY,     32'h1);
    checkOutput("rst_so",       b0.SPI_SO,       32'h0);

    // Mode 0: preload 0xA5, master sends 0x3C.
    push_tx(0, 32'hA5);
    @(negedge clkin);
    checkOutput("m0_tx_ready_full", b0.TX_READY, 32'h0);
    frame_start(0);
    shift_word(1'b0, 8, 8, 32'h3C, rx);
    frame_end();
    checkOutput("m0_miso",        rx,           32'hA5);
    checkOutput("m0_rx_data",     b0.RX_DATA,   32'h3C);
    checkOutput("m0_rx_valid",    b0.RX_VALID,  32'h1);
    checkOutput("m0_end_reload",  b0.UNDERRUN,  32'h1);
    checkOutput("m0_no_overrun",  b0.OVERRUN,   32'h0);
    pulse_rx_ready0();
    checkOutput("m0_rx_accepted", b0.RX_VALID,  32'h0);
    pulse_flag_clr0();
    checkOutput("m0_flag_clr",    b0.UNDERRUN,  32'h0);

    // Mode 3, 16 bit: three back-to-back words, TX refilled as it drains.
    fork
      begin
        push_tx(3, 32'hCAFE);
        push_tx(3, 32'h5A5A);
        push_tx(3, 32'h0123);
      end
      begin
        #200;
        frame_start(3);
        checkOutput("m3_frame_active", b3.FRAME_ACTIVE, 32'h1);
        shift_word(1'b1, 16, 16, 32'h1234, r0);
        shift_word(1'b1, 16, 16, 32'hBEEF, r1);
        shift_word(1'b1, 16, 16, 32'h0F0F, r2);
        frame_end();
      end
    join
    checkOutput("m3_rx_count", rxq3.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < rxq3.size()) checkOutput($sformatf("m3_rx_word%0d", i), rxq3[i], exp_rx3[i]);
    end
    checkOutput("m3_miso0",    r0,          32'hCAFE);
    checkOutput("m3_miso1",    r1,          32'h5A5A);
    checkOutput("m3_miso2",    r2,          32'h0123);
    checkOutput("m3_overrun",  b3.OVERRUN,  32'h0);
    checkOutput("m3_underrun", b3.UNDERRUN, 32'h0);

    // Mode 0, RX_READY held low across two words.
    frame_start(0);
    shift_word(1'b0, 8, 8, 32'h11, rx);
    shift_word(1'b0, 8, 8, 32'h22, rx);
    frame_end();
    checkOutput("ovr_rx_data",  b0.RX_DATA,  32'h11);
    checkOutput("ovr_rx_valid", b0.RX_VALID, 32'h1);
    checkOutput("ovr_set",      b0.OVERRUN,  32'h1);
    pulse_flag_clr0();
    checkOutput("ovr_clr",      b0.OVERRUN,  32'h0);
    checkOutput("ovr_rx_kept",  b0.RX_DATA,  32'h11);
    pulse_rx_ready0();
    checkOutput("ovr_drained",  b0.RX_VALID, 32'h0);

    // Mode 1 with no TX preload.
    frame_start(1);
    shift_word(1'b1, 8, 8, 32'h5A, rx);
    frame_end();
    checkOutput("m1_miso_ones", rx,          32'hFF);
    checkOutput("m1_underrun",  b1.UNDERRUN, 32'h1);
    checkOutput("m1_rx_data",   b1.RX_DATA,  32'h5A);
    checkOutput("m1_rx_valid",  b1.RX_VALID, 32'h1);

    // Mode 0: 5-bit aborted frame, then a full 0x81.
    frame_start(0);
    shift_word(1'b0, 8, 5, 32'hE7, rx);
    frame_end();
    checkOutput("part_no_valid",   b0.RX_VALID, 32'h0);
    checkOutput("part_no_overrun", b0.OVERRUN,  32'h0);
    frame_start(0);
    shift_word(1'b0, 8, 8, 32'h81, rx);
    frame_end();
    checkOutput("part_rx_data",  b0.RX_DATA,  32'h81);
    checkOutput("part_rx_valid", b0.RX_VALID, 32'h1);

    // Reset mid-word with RX valid, TX holding full and SO high.
    push_tx(0, 32'h96);
    frame_start(0);
    shift_word(1'b0, 8, 3, 32'hF0, rx);
    push_tx(0, 32'h69);
    checkOutput("mid_miso_bits", rx, 32'h4);
    @(posedge clkin); #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rx_data",  b0.RX_DATA,      32'h0);
    checkOutput("mid_rst_rx_valid", b0.RX_VALID,     32'h0);
    checkOutput("mid_rst_tx_ready", b0.TX_READY,     32'h1);
    checkOutput("mid_rst_so",       b0.SPI_SO,       32'h0);
    checkOutput("mid_rst_frame",    b0.FRAME_ACTIVE, 32'h0);
    checkOutput("mid_rst_underrun", b0.UNDERRUN,     32'h0);
    ssel = 1'b1;
    repeat (3) @(posedge clkin);
    #2 rst = 1'b0;
    #(4 * HALF);
    push_tx(0, 32'hD2);
    frame_start(0);
    shift_word(1'b0, 8, 8, 32'hC3, rx);
    frame_end();
    checkOutput("post_rst_miso",     rx,          32'hD2);
    checkOutput("post_rst_rx_data",  b0.RX_DATA,  32'hC3);
    checkOutput("post_rst_rx_valid", b0.RX_VALID, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
